// File: rtl/pipelined_mux_tree.sv
// Pipelined N-to-1 multiplexer.
// A binary tree of 2:1 stages resolves the select LSB first, with a register
// after every tree level. Each stage carries a valid bit and the full
// effective select as a tag, so the output reports which channel produced it.
// An optional scan counter can drive the select so that consecutive samples
// step through all channels.
module pipelined_mux_tree #(
  parameter int NUM_LEVELS = 5,
  parameter int DATA_W     = 1,
  localparam int SEL_W     = NUM_LEVELS - 1,
  localparam int WIDTH     = 2 ** SEL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH*DATA_W-1:0] in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    scan_en,
  input  logic                    scan_clr,
  output logic [DATA_W-1:0]       out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel
);

  logic [SEL_W-1:0] scan_r;
  logic [SEL_W-1:0] scan_nxt_s;
  logic [SEL_W-1:0] esel_s;

  // Effective select: external select, or the scan counter (forced to 0 on clear).
  always_comb begin
    esel_s = sel;
    if (!scan_en) begin
      esel_s = sel;
    end else if (scan_clr) begin
      esel_s = {SEL_W{1'b0}};
    end else begin
      esel_s = scan_r;
    end
  end

  // Scan counter next value: clear beats increment; a clear that coincides
  // with a scanned sample leaves the counter pointing at the following channel.
  always_comb begin
    scan_nxt_s = scan_r;
    if (scan_clr) begin
      if (in_valid && scan_en) begin
        scan_nxt_s = SEL_W'(1'b1);
      end else begin
        scan_nxt_s = {SEL_W{1'b0}};
      end
    end else if (scan_en && in_valid) begin
      scan_nxt_s = scan_r + SEL_W'(1'b1);
    end else begin
      scan_nxt_s = scan_r;
    end
  end

  // Scan counter register; wraps naturally at WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_r <= {SEL_W{1'b0}};
    end else begin
      scan_r <= scan_nxt_s;
    end
  end

  // One registered tree level per select bit; stage k consumes esel bit k-1.
  for (genvar k = 1; k <= SEL_W; k++) begin : g_stage
    localparam int N = 2 ** (SEL_W - k);

    logic [2*N*DATA_W-1:0] prev_data_s;
    logic                  prev_valid_s;
    logic [SEL_W-1:0]      prev_tag_s;
    logic [N*DATA_W-1:0]   mux_s;
    logic [N*DATA_W-1:0]   data_r;
    logic                  valid_r;
    logic [SEL_W-1:0]      tag_r;

    if (k == 1) begin : g_src
      assign prev_data_s  = in;
      assign prev_valid_s = in_valid;
      assign prev_tag_s   = esel_s;
    end else begin : g_src
      assign prev_data_s  = g_stage[k-1].data_r;
      assign prev_valid_s = g_stage[k-1].valid_r;
      assign prev_tag_s   = g_stage[k-1].tag_r;
    end

    // Pairwise 2:1 reduction of the previous level using this level's select bit.
    always_comb begin
      mux_s = '0;
      for (int j = 0; j < N; j++) begin
        if (prev_tag_s[k-1]) begin
          mux_s[j*DATA_W +: DATA_W] = prev_data_s[(2*j+1)*DATA_W +: DATA_W];
        end else begin
          mux_s[j*DATA_W +: DATA_W] = prev_data_s[(2*j)*DATA_W +: DATA_W];
        end
      end
    end

    // Level register: valid always advances, data and tag only move with a
    // valid sample so the last valid result stays visible during gaps.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_r  <= '0;
        valid_r <= 1'b0;
        tag_r   <= {SEL_W{1'b0}};
      end else begin
        valid_r <= prev_valid_s;
        if (prev_valid_s) begin
          data_r <= mux_s;
          tag_r  <= prev_tag_s;
        end
      end
    end
  end

  assign out       = g_stage[SEL_W].data_r;
  assign out_valid = g_stage[SEL_W].valid_r;
  assign out_sel   = g_stage[SEL_W].tag_r;

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Bench for pipelined_mux_tree: default 16:1 instance checked against a
// scoreboard fed by a reference model of the select/scan behaviour, plus a
// small 4:1 x 8-bit instance checked directly.
module tb_pipelined_mux_tree;

  localparam int SW = 4;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic [3:0]  sel;
  logic        in_valid;
  logic        scan_en;
  logic        scan_clr;
  logic        out;
  logic        out_valid;
  logic [3:0]  out_sel;

  logic [31:0] w_in;
  logic [1:0]  w_sel;
  logic        w_valid;
  logic [7:0]  w_out;
  logic        w_out_valid;
  logic [1:0]  w_out_sel;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  typedef struct {
    int         due;
    logic       d;
    logic [3:0] s;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] scan_m = 4'd0;
  logic       last_d = 1'b0;
  logic [3:0] last_s = 4'd0;

  pipelined_mux_tree #(.NUM_LEVELS(5), .DATA_W(1)) dut (
    .clk(clk), .rst(rst), .in(din), .sel(sel), .in_valid(in_valid),
    .scan_en(scan_en), .scan_clr(scan_clr),
    .out(out), .out_valid(out_valid), .out_sel(out_sel)
  );

  pipelined_mux_tree #(.NUM_LEVELS(3), .DATA_W(8)) dut_w (
    .clk(clk), .rst(rst), .in(w_in), .sel(w_sel), .in_valid(w_valid),
    .scan_en(1'b0), .scan_clr(1'b0),
    .out(w_out), .out_valid(w_out_valid), .out_sel(w_out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: each cycle either the due sample appears, or out_valid is low
  // and out/out_sel hold the last valid sample.
  always @(negedge clk) begin
    if (rst) begin
      last_d = 1'b0;
      last_s = 4'd0;
    end
    if (sb.size() > 0 && sb[0].due == ecount) begin
      check("out_valid", {31'd0, out_valid}, 32'd1);
      check("out", {31'd0, out}, {31'd0, sb[0].d});
      check("out_sel", {28'd0, out_sel}, {28'd0, sb[0].s});
      last_d = sb[0].d;
      last_s = sb[0].s;
      void'(sb.pop_front());
    end else begin
      check("idle_valid", {31'd0, out_valid}, 32'd0);
      check("held_out", {31'd0, out}, {31'd0, last_d});
      check("held_sel", {28'd0, out_sel}, {28'd0, last_s});
    end
  end

  // Apply one cycle of stimulus and record the expected result.
  task automatic drive(input logic [15:0] i, input logic [3:0] s, input logic v,
                       input logic en, input logic clr);
    logic [3:0] e;
    @(negedge clk);
    din = i; sel = s; in_valid = v; scan_en = en; scan_clr = clr;
    if (!en) e = s;
    else if (clr) e = 4'd0;
    else e = scan_m;
    if (v) sb.push_back('{ecount + SW, i[e], e});
    if (clr) scan_m = (v && en) ? 4'd1 : 4'd0;
    else if (en && v) scan_m = scan_m + 4'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    din = 16'h0; sel = 4'd0; in_valid = 1'b0; scan_en = 1'b0; scan_clr = 1'b0;
    w_in = 32'h0; w_sel = 2'd0; w_valid = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset and basic select.
    drive(16'hAAAA, 4'd14, 1'b1, 1'b0, 1'b0);
    idle(6);

    // Full sweep.
    for (int s = 0; s < 16; s++) drive(16'hAAAA, 4'(s), 1'b1, 1'b0, 1'b0);
    idle(5);

    // Scan wrap: 18 scanned samples.
    for (int n = 0; n < 18; n++) drive(16'h8001, 4'd0, 1'b1, 1'b1, 1'b0);
    // Advance counter to 9, then clear with a sample.
    for (int n = 0; n < 7; n++) drive(16'h8001, 4'd0, 1'b1, 1'b1, 1'b0);
    drive(16'h8001, 4'd0, 1'b1, 1'b1, 1'b1);
    drive(16'h8001, 4'd0, 1'b1, 1'b1, 1'b0);
    // Clear without a sample, then resume.
    drive(16'h8001, 4'd0, 1'b0, 1'b1, 1'b1);
    drive(16'h8001, 4'd0, 1'b1, 1'b1, 1'b0);
    // Leaving scan mode keeps the counter; clear with scan off clears only.
    drive(16'h00F0, 4'd5, 1'b1, 1'b0, 1'b0);
    drive(16'hFFFE, 4'd0, 1'b1, 1'b1, 1'b0);
    drive(16'h0F0F, 4'd9, 1'b1, 1'b0, 1'b1);
    drive(16'h0001, 4'd3, 1'b1, 1'b1, 1'b0);
    idle(5);

    // Random traffic with gaps, scan switching and occasional clears.
    for (int n = 0; n < 60; n++)
      drive(16'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom_range(0, 7) == 0));
    idle(5);

    // Reset mid-operation with three samples in flight.
    for (int n = 0; n < 4; n++) drive(16'hFFFF, 4'(n + 2), 1'b1, 1'b0, 1'b0);
    idle(1);
    #2 rst = 1'b1;
    #1;
    check("rst_out", {31'd0, out}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sel", {28'd0, out_sel}, 32'd0);
    sb.delete();
    scan_m = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(8);
    drive(16'h0000, 4'd0, 1'b1, 1'b1, 1'b0);
    idle(6);

    // Wide config: 4 channels of 8 bits.
    @(negedge clk);
    w_in = {8'hD4, 8'hC3, 8'hB2, 8'hA1}; w_sel = 2'd2; w_valid = 1'b1;
    @(negedge clk);
    w_valid = 1'b0; w_in = 32'h0; w_sel = 2'd0;
    check("w_valid_early", {31'd0, w_out_valid}, 32'd0);
    @(negedge clk);
    check("w_valid", {31'd0, w_out_valid}, 32'd1);
    check("w_out", {24'd0, w_out}, 32'h0000_00C3);
    check("w_sel", {30'd0, w_out_sel}, 32'd2);
    @(negedge clk);
    check("w_valid_after", {31'd0, w_out_valid}, 32'd0);
    check("w_out_held", {24'd0, w_out}, 32'h0000_00C3);

    idle(SW + 2);
    check("drain", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
